// File: rtl/det4x4_seq_ctrl_if.sv
// ============================================================================
// det4x4_seq_ctrl_if : start/done handshake and result bus of det4x4_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface det4x4_seq_ctrl_if;
  logic         start;
  logic [127:0] matriz_4x4;
  logic         busy;
  logic         done;
  logic [31:0]  det;
  logic         ovf;

  modport master (
    output start, matriz_4x4,
    input  busy, done, det, ovf
  );

  modport slave (
    input  start, matriz_4x4,
    output busy, done, det, ovf
  );
endinterface

`default_nettype wire

// File: rtl/det4x4_seq_ctrl.sv
// ============================================================================
// det4x4_seq_ctrl : 4x4 signed determinant, row-0 Laplace, one cofactor/clock
// Optional macro DET_SKIP_ZERO_EN skips cofactors whose a(0,k) is zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module det4x4_seq_ctrl #(
  parameter int ACC_W = 36
) (
  input  logic                clk,
  input  logic                rst,
  det4x4_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [127:0]              mat_q,   mat_d;
  logic signed [ACC_W-1:0]   acc_q,   acc_d;
  logic [1:0]                k_q,     k_d;
  logic [31:0]               det_q,   det_d;
  logic                      ovf_q,   ovf_d;

  logic [1:0]                w_first_k;
  logic [1:0]                w_next_k;
  logic                      w_last;

  logic signed [7:0]         w_a [0:3][0:3];
  logic signed [25:0]        w_b [0:2][0:2];
  logic [1:0]                w_c0, w_c1, w_c2;
  logic signed [25:0]        w_minor;
  logic signed [7:0]         w_a0k;
  logic signed [33:0]        w_prod;
  logic signed [33:0]        w_term;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic [ACC_W-32:0]         w_hi;

  function automatic logic signed [25:0] sx26(input logic signed [7:0] x);
    return {{18{x[7]}}, x};
  endfunction

`ifdef DET_SKIP_ZERO_EN
  logic [3:0] w_in_nz;
  logic [3:0] w_nz;

  // Lowest nonzero index wins; an all-zero row still runs one pass at k=0.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_in_nz[c] = |bus.matriz_4x4[127-8*c -: 8];
      w_nz[c]    = |mat_q[127-8*c -: 8];
    end
    w_first_k = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (w_in_nz[c]) w_first_k = c[1:0];
    end
    w_last   = 1'b1;
    w_next_k = k_q;
    for (int c = 3; c >= 0; c--) begin
      if (w_nz[c] && (c > int'(k_q))) begin
        w_last   = 1'b0;
        w_next_k = c[1:0];
      end
    end
  end
`else
  assign w_first_k = 2'd0;
  assign w_last    = (k_q == 2'd3);
  assign w_next_k  = k_q + 2'd1;
`endif

  // 3x3 minor of rows 1..3 with column k removed.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_a[r][c] = mat_q[127-8*(4*r+c) -: 8];
      end
    end
    w_c0 = (k_q == 2'd0)  ? 2'd1 : 2'd0;
    w_c1 = (k_q <= 2'd1)  ? 2'd2 : 2'd1;
    w_c2 = (k_q == 2'd3)  ? 2'd2 : 2'd3;
    for (int i = 0; i < 3; i++) begin
      w_b[i][0] = sx26(w_a[i+1][w_c0]);
      w_b[i][1] = sx26(w_a[i+1][w_c1]);
      w_b[i][2] = sx26(w_a[i+1][w_c2]);
    end
    w_minor = w_b[0][0] * (w_b[1][1] * w_b[2][2] - w_b[1][2] * w_b[2][1])
            - w_b[0][1] * (w_b[1][0] * w_b[2][2] - w_b[1][2] * w_b[2][0])
            + w_b[0][2] * (w_b[1][0] * w_b[2][1] - w_b[1][1] * w_b[2][0]);
    w_a0k   = w_a[0][k_q];
    w_prod  = $signed({{26{w_a0k[7]}}, w_a0k}) * $signed({{8{w_minor[25]}}, w_minor});
    w_term  = k_q[0] ? -w_prod : w_prod;
    w_acc_sum = acc_q + $signed({{(ACC_W-34){w_term[33]}}, w_term});
    w_hi      = w_acc_sum[ACC_W-1:31];
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    acc_d   = acc_q;
    k_d     = k_q;
    det_d   = det_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mat_d   = bus.matriz_4x4;
          acc_d   = '0;
          k_d     = w_first_k;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = w_acc_sum;
        if (w_last) begin
          det_d   = w_acc_sum[31:0];
          ovf_d   = ~((&w_hi) | ~(|w_hi));
          state_d = S_DONE;
        end else begin
          k_d = w_next_k;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      acc_q   <= '0;
      k_q     <= 2'd0;
      det_q   <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      det_q   <= det_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_CALC);
  assign bus.done = (state_q == S_DONE);
  assign bus.det  = det_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire
